// File: rtl/dest_reader_pkg.sv
// Shared encodings for the destination reader: FSM states and the position of
// the destination bit inside each data word.
package dest_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2
    } state_t;

    localparam int DEST_BIT = 4;

endpackage

// File: rtl/dest_reader_rr_arbiter2.sv
// Two-input round-robin grant: on contention the side not served last wins,
// otherwise the single requester is granted.
module rr_arbiter2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_src,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic w_gnt1;

    assign w_gnt1 = i_req1 && (!i_req0 || !i_last_src);
    assign o_gnt1 = w_gnt1;
    assign o_gnt0 = i_req0 && !w_gnt1;

endmodule

// File: rtl/dest_reader.sv
// Pops words from two destination FIFOs in round-robin order into a one-deep
// registered output stage, counting words per source and flagging misrouted ones.
module dest_reader
    import dest_reader_pkg::*;
#(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    input  logic          sink_ready,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          src_out,
    output logic [CW-1:0] D0_count,
    output logic [CW-1:0] D1_count,
    output logic          dest_error
);

    state_t        r_state;
    state_t        w_next;
    logic          r_last_src;
    logic [BW-1:0] r_data;
    logic          r_valid;
    logic          r_src;
    logic [CW-1:0] r_d0_count;
    logic [CW-1:0] r_d1_count;
    logic          r_dest_error;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_can_issue;
    logic          w_rd0;
    logic          w_rd1;
    logic          w_capture;
    logic          w_cap_src;
    logic [BW-1:0] w_cap_data;

    rr_arbiter2 u_arb (
        .i_req0     (!D0_empty),
        .i_req1     (!D1_empty),
        .i_last_src (r_last_src),
        .o_gnt0     (w_gnt0),
        .o_gnt1     (w_gnt1)
    );

    // Pop strobes are combinational, so they are masked directly by reset
    // to stay low while reset is held.
    assign w_can_issue = (!r_valid || sink_ready) && !reset;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next     = r_state;
        w_rd0      = 1'b0;
        w_rd1      = 1'b0;
        w_capture  = 1'b0;
        w_cap_src  = 1'b0;
        w_cap_data = D0_data_out;
        case (r_state)
            IDLE: begin
                if (w_can_issue) begin
                    w_rd0 = w_gnt0;
                    w_rd1 = w_gnt1;
                    if (w_gnt0)
                        w_next = WAIT0;
                    else if (w_gnt1)
                        w_next = WAIT1;
                end
            end
            WAIT0: begin
                w_capture  = 1'b1;
                w_cap_src  = 1'b0;
                w_cap_data = D0_data_out;
                w_next     = IDLE;
            end
            WAIT1: begin
                w_capture  = 1'b1;
                w_cap_src  = 1'b1;
                w_cap_data = D1_data_out;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_src   <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_src        <= 1'b0;
            r_d0_count   <= '0;
            r_d1_count   <= '0;
            r_dest_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_data     <= w_cap_data;
                r_valid    <= 1'b1;
                r_src      <= w_cap_src;
                r_last_src <= w_cap_src;
                if (w_cap_src)
                    r_d1_count <= r_d1_count + CW'(1);
                else
                    r_d0_count <= r_d0_count + CW'(1);
                if (w_cap_data[DEST_BIT] != w_cap_src)
                    r_dest_error <= 1'b1;
            end else if (r_valid && sink_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign D0_rd      = w_rd0;
    assign D1_rd      = w_rd1;
    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign src_out    = r_src;
    assign D0_count   = r_d0_count;
    assign D1_count   = r_d1_count;
    assign dest_error = r_dest_error;

endmodule

// File: tb/tb_dest_reader.sv
// Self-checking bench for dest_reader: two behavioural FIFOs feed the design,
// directed scenarios plus randomized rounds are compared against a merge model.
module tb_dest_reader;

    localparam int BW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          D0_empty, D1_empty;
    logic [BW-1:0] D0_data_out = '0;
    logic [BW-1:0] D1_data_out = '0;
    logic          D0_rd, D1_rd;
    logic          sink_ready = 1'b1;
    logic [BW-1:0] data_out;
    logic          valid_out, src_out;
    logic [CW-1:0] D0_count, D1_count;
    logic          dest_error;

    dest_reader #(.BW(BW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .D0_empty    (D0_empty),
        .D1_empty    (D1_empty),
        .D0_data_out (D0_data_out),
        .D1_data_out (D1_data_out),
        .D0_rd       (D0_rd),
        .D1_rd       (D1_rd),
        .sink_ready  (sink_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .src_out     (src_out),
        .D0_count    (D0_count),
        .D1_count    (D1_count),
        .dest_error  (dest_error)
    );

    always #5 clk = ~clk;

    // Behavioural FIFOs: read data appears the cycle after a pop strobe.
    logic [BW-1:0] mem0 [1024];
    logic [BW-1:0] mem1 [1024];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;

    assign D0_empty = (rp0 == wp0);
    assign D1_empty = (rp1 == wp1);

    always @(posedge clk) begin
        if (D0_rd && rp0 != wp0) begin
            D0_data_out <= mem0[rp0];
            rp0 <= rp0 + 1;
        end
        if (D1_rd && rp1 != wp1) begin
            D1_data_out <= mem1[rp1];
            rp1 <= rp1 + 1;
        end
    end

    // Every consumed word ({src, data}) in delivery order.
    logic [BW:0] obs [$];
    logic        both_rd = 1'b0;

    always @(negedge clk) begin
        if (!reset && valid_out && sink_ready)
            obs.push_back({src_out, data_out});
        if (D0_rd && D1_rd)
            both_rd = 1'b1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [BW-1:0] v);
        mem0[wp0] = v;
        wp0++;
    endtask

    task automatic push1(input logic [BW-1:0] v);
        mem1[wp1] = v;
        wp1++;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [BW:0] obs_at(input int idx);
        if (idx < obs.size())
            return obs[idx];
        return 'x;
    endfunction

    task automatic wait_words(input string tag, input int base, input int n,
                              input int budget, input bit rand_ready);
        for (int c = 0; c < budget && obs.size() < base + n; c++) begin
            if (rand_ready)
                sink_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sink_ready = 1'b1;
        check(tag, 32'(obs.size() - base), 32'(n));
    endtask

    // Reference: preloaded FIFOs drain alternately, starting with D1 after reset,
    // falling back to whichever side still has words.
    task automatic random_round(input int r);
        logic [BW-1:0] w0 [32];
        logic [BW-1:0] w1 [32];
        logic [BW:0]   exp_q [$];
        int            n0, n1, i0, i1, base;
        logic          last, pick, err;
        n0 = $urandom_range(2, 12);
        n1 = $urandom_range(2, 12);
        hold_reset();
        for (int k = 0; k < n0; k++) begin w0[k] = BW'($urandom); push0(w0[k]); end
        for (int k = 0; k < n1; k++) begin w1[k] = BW'($urandom); push1(w1[k]); end
        i0 = 0; i1 = 0; last = 1'b0; err = 1'b0;
        while (i0 < n0 || i1 < n1) begin
            pick = (i0 < n0 && i1 < n1) ? !last : (i1 < n1);
            if (pick) begin
                exp_q.push_back({1'b1, w1[i1]});
                err = err | (w1[i1][4] != 1'b1);
                i1++;
            end else begin
                exp_q.push_back({1'b0, w0[i0]});
                err = err | (w0[i0][4] != 1'b0);
                i0++;
            end
            last = pick;
        end
        base = obs.size();
        release_reset();
        wait_words($sformatf("rnd%0d_drain", r), base, n0 + n1, 400, 1'b1);
        tick();
        for (int k = 0; k < n0 + n1; k++)
            check($sformatf("rnd%0d_word%0d", r, k), 32'(obs_at(base + k)), 32'(exp_q[k]));
        check($sformatf("rnd%0d_d0_count", r), 32'(D0_count), 32'(n0 % (1 << CW)));
        check($sformatf("rnd%0d_d1_count", r), 32'(D1_count), 32'(n1 % (1 << CW)));
        check($sformatf("rnd%0d_dest_error", r), 32'(dest_error), 32'(err));
    endtask

    initial begin
        int base;

        // Reset state, with a word already waiting in D0.
        hold_reset();
        push0(6'h05);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_src", 32'(src_out), 0);
        check("rst_counts", 32'({D0_count, D1_count}), 0);
        check("rst_dest_error", 32'(dest_error), 0);
        check("rst_rd", 32'({D0_rd, D1_rd}), 0);

        // Single D0 word: pop at N, valid at N+2.
        release_reset();
        check("single_rd_n", 32'(D0_rd), 1);
        tick();
        check("single_rd_n1", 32'({D0_rd, D1_rd}), 0);
        check("single_valid_n1", 32'(valid_out), 0);
        tick();
        check("single_valid_n2", 32'(valid_out), 1);
        check("single_data", 32'(data_out), 32'h05);
        check("single_src", 32'(src_out), 0);
        check("single_d0_count", 32'(D0_count), 1);
        tick();

        // Both FIFOs loaded: alternation starting with D1.
        hold_reset();
        push0(6'h01); push0(6'h02);
        push1(6'h11); push1(6'h12);
        base = obs.size();
        release_reset();
        wait_words("rr_drain", base, 4, 40, 1'b0);
        check("rr_w0", 32'(obs_at(base + 0)), 32'({1'b1, 6'h11}));
        check("rr_w1", 32'(obs_at(base + 1)), 32'({1'b0, 6'h01}));
        check("rr_w2", 32'(obs_at(base + 2)), 32'({1'b1, 6'h12}));
        check("rr_w3", 32'(obs_at(base + 3)), 32'({1'b0, 6'h02}));
        check("rr_d0_count", 32'(D0_count), 2);
        check("rr_d1_count", 32'(D1_count), 2);

        // Back-pressure: pending word holds, no pop until sink_ready returns.
        hold_reset();
        sink_ready = 1'b0;
        push0(6'h01); push0(6'h02);
        release_reset();
        for (int c = 0; c < 10 && !valid_out; c++) tick();
        check("stall_valid", 32'(valid_out), 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_data", 32'(data_out), 32'h01);
            check("stall_rd", 32'({D0_rd, D1_rd}), 0);
        end
        sink_ready = 1'b1;
        #1;
        check("resume_rd", 32'(D0_rd), 1);
        tick();
        check("resume_cleared", 32'(valid_out), 0);
        tick();
        check("resume_valid", 32'(valid_out), 1);
        check("resume_data", 32'(data_out), 32'h02);
        tick();

        // Misrouted word on D0 sets a sticky error.
        hold_reset();
        push0(6'h10); push0(6'h03);
        push1(6'h11);
        base = obs.size();
        release_reset();
        wait_words("derr_drain", base, 3, 40, 1'b0);
        tick();
        check("derr_set", 32'(dest_error), 1);
        check("derr_d0_count", 32'(D0_count), 2);
        check("derr_d1_count", 32'(D1_count), 1);
        base = obs.size();
        push1(6'h12); push0(6'h0A);
        wait_words("derr_more", base, 2, 40, 1'b0);
        tick();
        check("derr_sticky", 32'(dest_error), 1);

        // Reset landing in WAIT1 discards the outstanding D1 word.
        hold_reset();
        push0(6'h07);
        push1(6'h15); push1(6'h16);
        release_reset();
        for (int c = 0; c < 5; c++) tick();
        check("w1_pre_counts", 32'({D0_count, D1_count}), 32'({8'd1, 8'd1}));
        reset = 1'b1;
        #1;
        base = obs.size();
        check("w1_rst_valid", 32'(valid_out), 0);
        check("w1_rst_data", 32'(data_out), 0);
        check("w1_rst_counts", 32'({D0_count, D1_count}), 0);
        check("w1_rst_rd", 32'({D0_rd, D1_rd}), 0);
        tick();
        tick();
        release_reset();
        for (int c = 0; c < 4; c++) tick();
        check("w1_no_word", 32'(obs.size() - base), 0);
        check("w1_d1_count", 32'(D1_count), 0);

        // Counter wrap: 2^CW + 1 words from D0.
        hold_reset();
        for (int k = 0; k < (1 << CW) + 1; k++) push0(BW'(k & 15));
        base = obs.size();
        release_reset();
        wait_words("wrap_drain", base, (1 << CW) + 1, 1200, 1'b0);
        tick();
        check("wrap_d0_count", 32'(D0_count), 1);

        for (int r = 0; r < 3; r++) random_round(r);

        check("rd_exclusive", 32'(both_rd), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
